paint_cursor_ctrl: RTL
======================

PAINT_CURSOR_CTRL -- requirements
Module: paint_cursor_ctrl

Interface
REQ-001 SHALL have parameter CANVAS_W, default 64, canvas width in pixels (2..256).
REQ-002 SHALL have parameter CANVAS_H, default 64, canvas height in pixels (2..256).
REQ-003 SHALL have parameter COLOR_W, default 12, pixel colour width.
REQ-004 SHALL have parameter DRAW_COLOR, default 12'hFFF, colour for left-button paint.
REQ-005 SHALL have parameter BG_COLOR, default 12'h000, colour for erase and clear.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port pkt_valid  input  1  one-cycle strobe, mouse packet present.
REQ-009 SHALL have ports pkt_btn_left, pkt_btn_right, pkt_btn_middle  input  1 each  button states.
REQ-010 SHALL have ports pkt_dx, pkt_dy  input  8 each  two's-complement signed deltas.
REQ-011 SHALL have ports fb_x, fb_y  output  8 each  framebuffer write coordinate.
REQ-012 SHALL have port fb_wdata  output  COLOR_W  framebuffer write colour.
REQ-013 SHALL have port fb_req  output  1  write request.
REQ-014 SHALL have port fb_ack  input  1  write accepted.
REQ-015 SHALL have ports cursor_x, cursor_y  output  8 each  current cursor position.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port pkt_drop  output  1  one-cycle pulse when a packet is discarded.

Function
REQ-018 SHALL implement states IDLE, UPDATE, WRITE, CLEAR.
REQ-019 IDLE: on pkt_valid, SHALL latch buttons and deltas and go to UPDATE.
REQ-020 UPDATE: SHALL compute cursor_x+dx and cursor_y+dy in at least 10-bit signed arithmetic, clamped to [0, CANVAS_W-1] and [0, CANVAS_H-1].
REQ-021 UPDATE: SHALL register the clamped cursor, then go to CLEAR if middle is set (REQ-033), else to WRITE if left or right is set, else to IDLE.
REQ-022 The updated cursor SHALL be visible 2 cycles after the pkt_valid edge; fb_req SHALL assert in the same cycle.
REQ-023 WRITE: fb_x/fb_y SHALL equal the new cursor; fb_wdata SHALL be DRAW_COLOR if left is set (left overrides right), else BG_COLOR.
REQ-024 fb_req, fb_x, fb_y and fb_wdata SHALL hold stable until fb_ack is sampled high with fb_req high; fb_req SHALL deassert on the next cycle.
REQ-025 WRITE SHALL return to IDLE after ack; fb_ack while fb_req is low SHALL be ignored.
REQ-026 pkt_valid in any state other than IDLE SHALL drop the packet, pulse pkt_drop for 1 cycle, and leave cursor and state unchanged.
REQ-027 pkt_valid in the cycle WRITE/CLEAR returns to IDLE SHALL be dropped, because the state is not yet IDLE.
REQ-028 Zero deltas with no buttons SHALL still pass through UPDATE, holding busy for 1 cycle.

Reset
REQ-029 Reset sampled high SHALL set state IDLE, cursor_x=CANVAS_W/2, cursor_y=CANVAS_H/2, and fb_req=0.
REQ-030 Reset sampled high SHALL set fb_x=0, fb_y=0, fb_wdata=0, busy=0, pkt_drop=0, and clear the sweep counters.
REQ-031 Reset mid-WRITE or mid-CLEAR SHALL abort the operation with no further requests; fb_req SHALL be low in the cycle after the reset edge.
REQ-032 Reset SHALL override pkt_valid and fb_ack in the same cycle.

Configuration
REQ-033 With macro PAINT_CLEAR_EN defined, middle SHALL take priority over left/right and enter CLEAR.
REQ-034 CLEAR SHALL issue CANVAS_W*CANVAS_H writes of BG_COLOR in raster order (x fastest, (0,0) first), one per ack under the REQ-024 handshake, then go to IDLE; the cursor is unchanged.
REQ-035 Without PAINT_CLEAR_EN, the CLEAR state and its counters SHALL be absent and pkt_btn_middle SHALL be ignored.

Verification
REQ-036 Reset, then pkt dx=+5 dy=-3 with no buttons -> cursor (37,29) two cycles later, fb_req never high, busy high 1 cycle.
REQ-037 Cursor (62,1) with dx=+10 dy=-4 -> (63,0); cursor x=32 with dx=8'h80 -> x=0.
REQ-038 Left pressed with zero deltas, ack delayed 3 cycles -> fb_req held 4 cycles at (32,32) with DRAW_COLOR stable, low the cycle after ack.
REQ-039 Left+right -> DRAW_COLOR; right only -> BG_COLOR.
REQ-040 pkt_valid during WRITE -> pkt_drop 1-cycle pulse, cursor and pending write unchanged.
REQ-041 PAINT_CLEAR_EN with CANVAS_W=CANVAS_H=4, middle pressed -> 16 BG writes (0,0)..(3,3), busy low after 16th ack; reset after 5th ack -> fb_req low next cycle, cursor (2,2).

Source files
------------

// File: rtl/paint_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// paint_cursor_ctrl
//
// Purpose:
//   Mouse-driven paint cursor. Each accepted mouse packet moves a cursor by
//   signed deltas, clamped to the canvas. The packet's buttons then decide the
//   action:
//     - left  : paint one pixel in DRAW_COLOR at the new cursor position
//     - right : erase one pixel (BG_COLOR) at the new cursor position
//     - middle: clear the whole canvas (only when PAINT_CLEAR_EN is defined)
//   Framebuffer writes use a req/ack handshake. Packets that arrive while the
//   controller is busy are discarded and flagged with pkt_drop.
//
// Optional feature:
//   `define PAINT_CLEAR_EN -> a middle click sweeps BG_COLOR over every pixel
//   in raster order. Without it the CLEAR state and its counters are absent,
//   and pkt_btn_middle is ignored.
//
// Ports:
//   clk                       : single clock, rising edge
//   reset                     : synchronous, active-high
//   pkt_valid                 : one-cycle strobe, mouse packet present
//   pkt_btn_left/right/middle : button states of the packet
//   pkt_dx, pkt_dy            : two's-complement signed deltas
//   fb_x, fb_y, fb_wdata      : framebuffer write coordinate and colour
//   fb_req / fb_ack           : write request / write accepted
//   cursor_x, cursor_y        : current cursor position
//   busy                      : high whenever the state is not IDLE
//   pkt_drop                  : one-cycle pulse when a packet is discarded
// -----------------------------------------------------------------------------
module paint_cursor_ctrl #(
    parameter int                 CANVAS_W   = 64,
    parameter int                 CANVAS_H   = 64,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] DRAW_COLOR = 12'hFFF,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 12'h000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pkt_valid,
    input  logic               pkt_btn_left,
    input  logic               pkt_btn_right,
    input  logic               pkt_btn_middle,
    input  logic [7:0]         pkt_dx,
    input  logic [7:0]         pkt_dy,
    output logic [7:0]         fb_x,
    output logic [7:0]         fb_y,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               fb_req,
    input  logic               fb_ack,
    output logic [7:0]         cursor_x,
    output logic [7:0]         cursor_y,
    output logic               busy,
    output logic               pkt_drop
);

`ifdef PAINT_CLEAR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UPDATE = 2'd1, ST_WRITE = 2'd2, ST_CLEAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_UPDATE = 2'd1, ST_WRITE = 2'd2} state_t;
`endif

    localparam logic signed [9:0] MAX_X = 10'(CANVAS_W - 1);
    localparam logic signed [9:0] MAX_Y = 10'(CANVAS_H - 1);

    // Position + signed delta in 10-bit signed arithmetic, clamped to [0, max_v].
    function automatic logic [7:0] clamp_add(input logic [7:0] pos,
                                             input logic [7:0] delta,
                                             input logic signed [9:0] max_v);
        logic signed [9:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{2{delta[7]}}, delta});
        if (sum < 10'sd0) begin
            return 8'd0;
        end else if (sum > max_v) begin
            return max_v[7:0];
        end else begin
            return sum[7:0];
        end
    endfunction

    state_t               state_r, next_state_s;
    logic                 lat_left_r, lat_right_r, lat_left_s, lat_right_s;
    logic [7:0]           lat_dx_r, lat_dy_r, lat_dx_s, lat_dy_s;
    logic [7:0]           cursor_x_r, cursor_y_r, cursor_x_s, cursor_y_s;
    logic [7:0]           fb_x_r, fb_y_r, fb_x_s, fb_y_s;
    logic [COLOR_W-1:0]   fb_wdata_r, fb_wdata_s;
    logic                 fb_req_r, fb_req_s;
    logic                 busy_r, pkt_drop_r;
    logic [7:0]           new_x_s, new_y_s;
    logic                 handshake_s;
`ifdef PAINT_CLEAR_EN
    logic                 lat_mid_r, lat_mid_s;
    logic [7:0]           clr_x_r, clr_y_r, clr_x_s, clr_y_s;
    logic                 clr_last_s;
`else
    logic                 unused_mid_s;
    assign unused_mid_s = pkt_btn_middle;
`endif

    assign new_x_s     = clamp_add(cursor_x_r, lat_dx_r, MAX_X);
    assign new_y_s     = clamp_add(cursor_y_r, lat_dy_r, MAX_Y);
    // An ack only counts while a request is actually outstanding.
    assign handshake_s = fb_req_r & fb_ack;
`ifdef PAINT_CLEAR_EN
    assign clr_last_s  = (clr_x_r == 8'(CANVAS_W - 1)) && (clr_y_r == 8'(CANVAS_H - 1));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pkt_valid) begin
                    next_state_s = ST_UPDATE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_UPDATE: begin
`ifdef PAINT_CLEAR_EN
                if (lat_mid_r) begin
                    next_state_s = ST_CLEAR;
                end else
`endif
                if (lat_left_r || lat_right_r) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (handshake_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WRITE;
                end
            end
`ifdef PAINT_CLEAR_EN
            ST_CLEAR: begin
                if (handshake_s && clr_last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR;
                end
            end
`endif
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and framebuffer outputs.
    always_comb begin
        lat_left_s  = lat_left_r;
        lat_right_s = lat_right_r;
        lat_dx_s    = lat_dx_r;
        lat_dy_s    = lat_dy_r;
        cursor_x_s  = cursor_x_r;
        cursor_y_s  = cursor_y_r;
        fb_x_s      = fb_x_r;
        fb_y_s      = fb_y_r;
        fb_wdata_s  = fb_wdata_r;
        fb_req_s    = fb_req_r;
`ifdef PAINT_CLEAR_EN
        lat_mid_s   = lat_mid_r;
        clr_x_s     = clr_x_r;
        clr_y_s     = clr_y_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (pkt_valid) begin
                    lat_left_s  = pkt_btn_left;
                    lat_right_s = pkt_btn_right;
                    lat_dx_s    = pkt_dx;
                    lat_dy_s    = pkt_dy;
`ifdef PAINT_CLEAR_EN
                    lat_mid_s   = pkt_btn_middle;
`endif
                end else begin
                    fb_req_s = 1'b0;
                end
            end
            ST_UPDATE: begin
                cursor_x_s = new_x_s;
                cursor_y_s = new_y_s;
`ifdef PAINT_CLEAR_EN
                if (lat_mid_r) begin
                    clr_x_s    = 8'd0;
                    clr_y_s    = 8'd0;
                    fb_x_s     = 8'd0;
                    fb_y_s     = 8'd0;
                    fb_wdata_s = BG_COLOR;
                    fb_req_s   = 1'b1;
                end else
`endif
                if (lat_left_r || lat_right_r) begin
                    fb_x_s     = new_x_s;
                    fb_y_s     = new_y_s;
                    // Left wins when both buttons are held.
                    fb_wdata_s = lat_left_r ? DRAW_COLOR : BG_COLOR;
                    fb_req_s   = 1'b1;
                end else begin
                    fb_req_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (handshake_s) begin
                    fb_req_s = 1'b0;
                end else begin
                    fb_req_s = fb_req_r;
                end
            end
`ifdef PAINT_CLEAR_EN
            ST_CLEAR: begin
                if (handshake_s && clr_last_s) begin
                    fb_req_s = 1'b0;
                end else if (handshake_s) begin
                    // Raster order: x wraps into the next row.
                    if (clr_x_r == 8'(CANVAS_W - 1)) begin
                        clr_x_s = 8'd0;
                        clr_y_s = clr_y_r + 8'd1;
                    end else begin
                        clr_x_s = clr_x_r + 8'd1;
                        clr_y_s = clr_y_r;
                    end
                    fb_x_s = clr_x_s;
                    fb_y_s = clr_y_s;
                end else begin
                    fb_req_s = fb_req_r;
                end
            end
`endif
            default: fb_req_s = 1'b0;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_left_r  <= 1'b0;
            lat_right_r <= 1'b0;
            lat_dx_r    <= 8'd0;
            lat_dy_r    <= 8'd0;
            cursor_x_r  <= 8'(CANVAS_W / 2);
            cursor_y_r  <= 8'(CANVAS_H / 2);
            fb_x_r      <= 8'd0;
            fb_y_r      <= 8'd0;
            fb_wdata_r  <= {COLOR_W{1'b0}};
            fb_req_r    <= 1'b0;
            busy_r      <= 1'b0;
            pkt_drop_r  <= 1'b0;
`ifdef PAINT_CLEAR_EN
            lat_mid_r   <= 1'b0;
            clr_x_r     <= 8'd0;
            clr_y_r     <= 8'd0;
`endif
        end else begin
            lat_left_r  <= lat_left_s;
            lat_right_r <= lat_right_s;
            lat_dx_r    <= lat_dx_s;
            lat_dy_r    <= lat_dy_s;
            cursor_x_r  <= cursor_x_s;
            cursor_y_r  <= cursor_y_s;
            fb_x_r      <= fb_x_s;
            fb_y_r      <= fb_y_s;
            fb_wdata_r  <= fb_wdata_s;
            fb_req_r    <= fb_req_s;
            // Registered from next state so busy tracks state exactly.
            busy_r      <= (next_state_s != ST_IDLE);
            pkt_drop_r  <= pkt_valid && (state_r != ST_IDLE);
`ifdef PAINT_CLEAR_EN
            lat_mid_r   <= lat_mid_s;
            clr_x_r     <= clr_x_s;
            clr_y_r     <= clr_y_s;
`endif
        end
    end

    assign fb_x     = fb_x_r;
    assign fb_y     = fb_y_r;
    assign fb_wdata = fb_wdata_r;
    assign fb_req   = fb_req_r;
    assign cursor_x = cursor_x_r;
    assign cursor_y = cursor_y_r;
    assign busy     = busy_r;
    assign pkt_drop = pkt_drop_r;

endmodule
